// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode/state types, LED count and cfg field positions for the LED bank sequencer
package led_seq_pkg;

  localparam int NUM_LEDS = 24;

  localparam int CFG_MODE_LSB   = 0;
  localparam int CFG_MODE_W     = 2;
  localparam int CFG_BRIGHT_LSB = 2;
  localparam int CFG_BRIGHT_W   = 2;
  localparam int CFG_SPEED_LSB  = 4;
  localparam int CFG_SPEED_W    = 4;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_STATIC  = 3'd1,
    ST_CHASE   = 3'd2,
    ST_BOUNCE  = 3'd3,
    ST_RESTART = 3'd4
  } state_e;

  // RESTART reports mode 0 so led[6:5] shows it as inactive
  function automatic mode_e state_mode(input state_e s);
    case (s)
      ST_STATIC: return MODE_STATIC;
      ST_CHASE:  return MODE_CHASE;
      ST_BOUNCE: return MODE_BOUNCE;
      default:   return MODE_OFF;
    endcase
  endfunction

  function automatic state_e mode_state(input mode_e m);
    case (m)
      MODE_STATIC: return ST_STATIC;
      MODE_CHASE:  return ST_CHASE;
      MODE_BOUNCE: return ST_BOUNCE;
      default:     return ST_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_seq_tick.sv
// rtl/led_seq_tick.sv - prescaler plus speed-scaled step counter; step pulses every (speed+1)*2^DIV_W cycles
module led_seq_tick #(
  parameter int DIV_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [3:0] speed,
  output logic       step
);

  logic [DIV_W-1:0] presc;
  logic [3:0]       step_cnt;
  logic             base_tick;

  assign base_tick = &presc;
  // >= lets a speed decrease mid-count step on the very next base tick
  assign step      = base_tick && !clr && (step_cnt >= speed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      step_cnt <= '0;
    end else if (clr) begin
      presc    <= '0;
      step_cnt <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (base_tick) begin
        step_cnt <= (step_cnt >= speed) ? '0 : step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_bank_sequencer.sv
// rtl/led_bank_sequencer.sv - LED bank pattern sequencer top; define LED_SEQ_DEBOUNCE_EN to debounce dsw2 before it reaches cfg
module led_bank_sequencer
  import led_seq_pkg::*;
#(
  parameter int DIV_W = 20
`ifdef LED_SEQ_DEBOUNCE_EN
  , parameter int DB_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dsw0,
  input  logic [7:0] dsw1,
  input  logic [7:0] dsw2,
  output logic [7:0] lb0,
  output logic [7:0] lb1,
  output logic [7:0] lb2,
  output logic [7:0] led
);

  localparam logic [4:0] POS_MAX = 5'(NUM_LEDS - 1);

  logic [7:0] dsw0_m, dsw1_m, dsw2_m;
  logic [7:0] dsw0s, dsw1s, dsw2s;
  logic [7:0] cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsw0_m <= '0;
      dsw1_m <= '0;
      dsw2_m <= '0;
      dsw0s  <= '0;
      dsw1s  <= '0;
      dsw2s  <= '0;
    end else begin
      dsw0_m <= dsw0;
      dsw1_m <= dsw1;
      dsw2_m <= dsw2;
      dsw0s  <= dsw0_m;
      dsw1s  <= dsw1_m;
      dsw2s  <= dsw2_m;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt;
  logic [7:0]      db_last;

  // any change in the synced config restarts the hold count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      db_last <= '0;
      cfg     <= '0;
    end else begin
      db_last <= dsw2s;
      if (dsw2s != db_last) begin
        db_cnt <= '0;
      end else if (db_cnt == '1) begin
        cfg <= dsw2s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end
`else
  assign cfg = dsw2s;
`endif

  mode_e      cfg_mode;
  logic [1:0] bright;
  logic [3:0] speed;

  assign cfg_mode = mode_e'(cfg[CFG_MODE_LSB +: CFG_MODE_W]);
  assign bright   = cfg[CFG_BRIGHT_LSB +: CFG_BRIGHT_W];
  assign speed    = cfg[CFG_SPEED_LSB +: CFG_SPEED_W];

  state_e     state, state_d;
  logic [4:0] pos, pos_d;
  logic       dir_dn, dir_dn_d;
  logic       hb, hb_d;
  logic       step;

  led_seq_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_RESTART),
    .speed (speed),
    .step  (step)
  );

  always_comb begin
    state_d  = state;
    pos_d    = pos;
    dir_dn_d = dir_dn;
    hb_d     = hb;
    if (state == ST_RESTART) begin
      state_d  = mode_state(cfg_mode);
      pos_d    = '0;
      dir_dn_d = 1'b0;
    end else if (state_mode(state) != cfg_mode) begin
      // a mode change outranks a coincident step
      state_d  = ST_RESTART;
      pos_d    = '0;
      dir_dn_d = 1'b0;
    end else if (step) begin
      hb_d = ~hb;
      case (state)
        ST_CHASE: pos_d = (pos == POS_MAX) ? '0 : pos + 1'b1;
        ST_BOUNCE: begin
          if (!dir_dn) begin
            if (pos == POS_MAX) begin
              dir_dn_d = 1'b1;
              pos_d    = pos - 1'b1;
            end else begin
              pos_d = pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              dir_dn_d = 1'b0;
              pos_d    = pos + 1'b1;
            end else begin
              pos_d = pos - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic [NUM_LEDS-1:0] pattern_d;

  always_comb begin
    pattern_d = '0;
    case (state_d)
      ST_STATIC:           pattern_d = '1;
      ST_CHASE, ST_BOUNCE: pattern_d = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos_d;
      default: ;
    endcase
  end

  logic [7:0] pwm_cnt;
  logic       pwm_on;

  assign pwm_on = (pwm_cnt[7:6] <= bright);

  // outputs register the next-state view so a mode change shows one cycle after RESTART
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      pos     <= '0;
      dir_dn  <= 1'b0;
      hb      <= 1'b0;
      pwm_cnt <= '0;
      lb0     <= '0;
      lb1     <= '0;
      lb2     <= '0;
      led     <= '0;
    end else begin
      state   <= state_d;
      pos     <= pos_d;
      dir_dn  <= dir_dn_d;
      hb      <= hb_d;
      pwm_cnt <= pwm_cnt + 1'b1;
      lb0     <= pattern_d[7:0]   & dsw0s & {8{pwm_on}};
      lb1     <= pattern_d[15:8]  & dsw1s & {8{pwm_on}};
      lb2     <= pattern_d[23:16] & {8{pwm_on}};
      led     <= {hb_d, state_mode(state_d), pos_d};
    end
  end

endmodule

// File: tb/tb_led_bank_sequencer.sv
// tb/tb_led_bank_sequencer.sv - self-checking bench for led_bank_sequencer with DIV_W=4
module tb_led_bank_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dsw0  = 8'h00;
  logic [7:0] dsw1  = 8'h00;
  logic [7:0] dsw2  = 8'h00;
  logic [7:0] lb0, lb1, lb2, led;
  logic [23:0] lbs;

  int n_checks = 0;
  int n_fail   = 0;

  assign lbs = {lb2, lb1, lb0};

  always #5 clk = ~clk;

  led_bank_sequencer #(
    .DIV_W(4)
`ifdef LED_SEQ_DEBOUNCE_EN
    , .DB_W(4)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dsw0  (dsw0),
    .dsw1  (dsw1),
    .dsw2  (dsw2),
    .lb0   (lb0),
    .lb1   (lb1),
    .lb2   (lb2),
    .led   (led)
  );

  function automatic logic [23:0] onehot(input int p);
    logic [23:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [23:0] masked(input logic [23:0] pat, input logic [7:0] m0, input logic [7:0] m1);
    return {pat[23:16], pat[15:8] & m1, pat[7:0] & m0};
  endfunction

  // ping-pong across 24 LEDs without dwell has a 46-step period
  function automatic int bounce_pos(input int k);
    int p;
    p = k % 46;
    return (p <= 23) ? p : 46 - p;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dsw0  = 8'hFF;
    dsw1  = 8'hFF;
    dsw2  = 8'h0D;
    tick(3);
    n_checks++;
    if ({lbs, led} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", {lbs, led}, 32'h0);
    end
    rst_n = 1'b1;
    tick(3);
    n_checks++;
    if (lbs !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_lat3: got %h expected %h", lbs, 24'h0);
    end
    tick(1);
    n_checks++;
    if (lbs !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL reset_lat4: got %h expected %h", lbs, 24'hFFFFFF);
    end
    n_checks++;
    if (led[6:0] !== 7'h20) begin
      n_fail++;
      $display("FAIL reset_led: got %h expected %h", led[6:0], 7'h20);
    end
  endtask

  task automatic test_chase(input logic [7:0] m0, input logic [7:0] m1, input logic [3:0] spd);
    int   period;
    logic prev_hb;
    period = (int'(spd) + 1) * 16;
    dsw0 = m0;
    dsw1 = m1;
    dsw2 = {spd, 2'd3, 2'd2};
    tick(4);
    n_checks++;
    if ({lbs, led[6:0]} !== {masked(onehot(0), m0, m1), 2'd2, 5'd0}) begin
      n_fail++;
      $display("FAIL chase_start: got %h expected %h", {lbs, led[6:0]}, {masked(onehot(0), m0, m1), 2'd2, 5'd0});
    end
    prev_hb = led[7];
    for (int k = 1; k <= 24; k++) begin
      tick(period - 1);
      n_checks++;
      if ({lbs, led[7]} !== {masked(onehot((k - 1) % 24), m0, m1), prev_hb}) begin
        n_fail++;
        $display("FAIL chase_hold k=%0d: got %h expected %h", k, {lbs, led[7]}, {masked(onehot((k - 1) % 24), m0, m1), prev_hb});
      end
      tick(1);
      prev_hb = ~prev_hb;
      n_checks++;
      if ({lbs, led} !== {masked(onehot(k % 24), m0, m1), prev_hb, 2'd2, 5'(k % 24)}) begin
        n_fail++;
        $display("FAIL chase_step k=%0d: got %h expected %h", k, {lbs, led}, {masked(onehot(k % 24), m0, m1), prev_hb, 2'd2, 5'(k % 24)});
      end
    end
  endtask

  task automatic test_bounce(input logic [7:0] m0, input logic [7:0] m1, input logic [3:0] spd);
    int   period;
    logic prev_hb;
    period = (int'(spd) + 1) * 16;
    dsw0 = m0;
    dsw1 = m1;
    dsw2 = {spd, 2'd3, 2'd3};
    tick(4);
    n_checks++;
    if ({lbs, led[6:0]} !== {masked(onehot(0), m0, m1), 2'd3, 5'd0}) begin
      n_fail++;
      $display("FAIL bounce_start: got %h expected %h", {lbs, led[6:0]}, {masked(onehot(0), m0, m1), 2'd3, 5'd0});
    end
    prev_hb = led[7];
    for (int k = 1; k <= 47; k++) begin
      tick(period - 1);
      n_checks++;
      if (led[4:0] !== 5'(bounce_pos(k - 1))) begin
        n_fail++;
        $display("FAIL bounce_hold k=%0d: got %0d expected %0d", k, led[4:0], bounce_pos(k - 1));
      end
      tick(1);
      prev_hb = ~prev_hb;
      n_checks++;
      if ({lbs, led} !== {masked(onehot(bounce_pos(k)), m0, m1), prev_hb, 2'd3, 5'(bounce_pos(k))}) begin
        n_fail++;
        $display("FAIL bounce_step k=%0d: got %h expected %h", k, {lbs, led}, {masked(onehot(bounce_pos(k)), m0, m1), prev_hb, 2'd3, 5'(bounce_pos(k))});
      end
    end
  endtask

  task automatic test_pwm();
    logic [7:0] m0, m1;
    int         on_cnt, bad;
    logic       on;
    for (int b = 0; b < 4; b++) begin
      m0 = (b == 0) ? 8'hA5 : (8'($urandom) | 8'h01);
      m1 = 8'($urandom);
      dsw0 = m0;
      dsw1 = m1;
      dsw2 = {4'($urandom), 2'(b), 2'd1};
      tick(8);
      on_cnt = 0;
      bad    = 0;
      for (int c = 0; c < 256; c++) begin
        tick(1);
        on = (lb0 == m0);
        if (on) on_cnt++;
        if ((!on && lb0 != 8'h00) || lb1 !== (on ? m1 : 8'h00) || lb2 !== (on ? 8'hFF : 8'h00)) bad++;
      end
      n_checks++;
      if (on_cnt != 64 * (b + 1)) begin
        n_fail++;
        $display("FAIL pwm_duty b=%0d: got %0d on-cycles expected %0d", b, on_cnt, 64 * (b + 1));
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL pwm_gating b=%0d: got %0d bad samples expected 0", b, bad);
      end
    end
  endtask

  task automatic test_mode_change_on_step();
    logic prev_hb;
    dsw0 = 8'hFF;
    dsw1 = 8'hFF;
    dsw2 = 8'h0E;
    tick(4);
    tick(160);
    n_checks++;
    if (led[6:0] !== {2'd2, 5'd10}) begin
      n_fail++;
      $display("FAIL mc_pos10: got %h expected %h", led[6:0], {2'd2, 5'd10});
    end
    prev_hb = led[7];
    // cfg turns BOUNCE in the cycle whose edge carries step 11
    tick(13);
    dsw2 = 8'h0F;
    tick(2);
    n_checks++;
    if (led !== {prev_hb, 2'd2, 5'd10}) begin
      n_fail++;
      $display("FAIL mc_pre: got %h expected %h", led, {prev_hb, 2'd2, 5'd10});
    end
    tick(1);
    n_checks++;
    if ({lbs, led[7:5]} !== {24'h0, prev_hb, 2'd0}) begin
      n_fail++;
      $display("FAIL mc_restart: got %h expected %h", {lbs, led[7:5]}, {24'h0, prev_hb, 2'd0});
    end
    tick(1);
    n_checks++;
    if ({lbs, led} !== {onehot(0), prev_hb, 2'd3, 5'd0}) begin
      n_fail++;
      $display("FAIL mc_bounce: got %h expected %h", {lbs, led}, {onehot(0), prev_hb, 2'd3, 5'd0});
    end
    tick(15);
    n_checks++;
    if (led[4:0] !== 5'd0) begin
      n_fail++;
      $display("FAIL mc_full_period: got %0d expected 0", led[4:0]);
    end
    tick(1);
    n_checks++;
    if ({lbs, led} !== {onehot(1), ~prev_hb, 2'd3, 5'd1}) begin
      n_fail++;
      $display("FAIL mc_first_step: got %h expected %h", {lbs, led}, {onehot(1), ~prev_hb, 2'd3, 5'd1});
    end
  endtask

  task automatic test_mid_reset();
    dsw0 = 8'hFF;
    dsw1 = 8'hFF;
    dsw2 = 8'h0E;
    tick(4 + 16 * 5 + 7);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({lbs, led} !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_clear: got %h expected %h", {lbs, led}, 32'h0);
    end
    tick(1);
    rst_n = 1'b1;
    tick(4);
    n_checks++;
    if ({lbs, led} !== {onehot(0), 1'b0, 2'd2, 5'd0}) begin
      n_fail++;
      $display("FAIL midrst_restart: got %h expected %h", {lbs, led}, {onehot(0), 1'b0, 2'd2, 5'd0});
    end
    tick(15);
    n_checks++;
    if (led[4:0] !== 5'd0) begin
      n_fail++;
      $display("FAIL midrst_no_pending: got %0d expected 0", led[4:0]);
    end
    tick(1);
    n_checks++;
    if ({lbs, led} !== {onehot(1), 1'b1, 2'd2, 5'd1}) begin
      n_fail++;
      $display("FAIL midrst_step: got %h expected %h", {lbs, led}, {onehot(1), 1'b1, 2'd2, 5'd1});
    end
  endtask

  initial begin
    test_reset();
    test_chase(8'hFF, 8'hFF, 4'd0);
    test_bounce(8'($urandom), 8'($urandom), 4'($urandom_range(0, 1)));
    test_chase(8'($urandom), 8'($urandom), 4'($urandom_range(1, 3)));
    test_pwm();
    test_mode_change_on_step();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_bank_sequencer.md
Name: led_bank_sequencer

Overview:
- Pattern controller for the three 8-bit LED banks and the 8 user LEDs on the IO board; sits between the DIP switch inputs and the LED pins in the top level.
- Synchronizes the switch banks, decodes a mode/speed/brightness config from dsw2, and sequences a 24-bit pattern across lb0..lb2.
- Gates the pattern with per-bank masks (dsw0, dsw1) and a PWM brightness duty.

Parameters:
- DIV_W, 20, prescaler width; base tick every 2^DIV_W clk cycles (benches use 4).
- NUM_LEDS, 24, pattern length (fixed 3x8; localparam in package, not overridable).
- DB_W, 16, debounce counter width (used only with LED_SEQ_DEBOUNCE_EN).

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- dsw0  in  8  mask for lb0 (async)
- dsw1  in  8  mask for lb1 (async)
- dsw2  in  8  config: [1:0] mode, [3:2] brightness, [7:4] speed (async)
- lb0  out  8  LED bank 0 = pattern[7:0]
- lb1  out  8  LED bank 1 = pattern[15:8]
- lb2  out  8  LED bank 2 = pattern[23:16]
- led  out  8  status: [4:0] position, [6:5] active mode, [7] heartbeat

Behaviour:
- Reset (async assert, sync release): lb0/lb1/lb2/led = 0; sync regs = 0; state OFF; pos = 0; dir = up; prescaler, step and PWM counters = 0.
- Sync: all 24 switch bits pass through 2 flops; the decoders see only the synced copies (cfg).
- Modes (cfg[1:0]): 0 OFF, 1 STATIC, 2 CHASE, 3 BOUNCE.
- FSM states: OFF, STATIC, CHASE, BOUNCE, RESTART.
- Any state whose mode != cfg mode goes to RESTART for exactly 1 cycle. RESTART clears pos, dir, prescaler and step counter, then enters the state for cfg mode.
- The mode is re-evaluated on exit from RESTART.
- Prescaler: DIV_W-bit counter; base_tick when it wraps.
- Step counter: 4 bits; on base_tick, if step_cnt >= speed then step=1 and step_cnt=0, else step_cnt+1.
- Step period = (speed+1)*2^DIV_W cycles. The >= compare makes a speed decrease mid-count step on the next base_tick.
- Pattern by state:
  - OFF: all 0.
  - STATIC: all 1.
  - CHASE/BOUNCE: one-hot at pos.
- CHASE: on step, pos+1; 23 wraps to 0.
- BOUNCE: on step, pos moves in dir. At pos 23 with dir up, dir flips down and pos goes to 22. At pos 0 with dir down, dir flips up and pos goes to 1. No dwell at either end.
- Simultaneous mode change and step: mode change wins; step dropped.
- PWM: free-running 8-bit counter; pwm_on = (pwm_cnt[7:6] <= brightness). Duty: 0 -> 25%, 1 -> 50%, 2 -> 75%, 3 -> 100%.
- Outputs are registered:
  - lb0 = pattern[7:0] & dsw0s & {8{pwm_on}}
  - lb1 = pattern[15:8] & dsw1s & {8{pwm_on}}
  - lb2 = pattern[23:16] & {8{pwm_on}} (lb2 is unmasked)
- led[4:0] = pos; led[6:5] = active mode (0 in RESTART); led[7] toggles on every step.
- Latency:
  - Switch edge to lb change in STATIC: 3 clk (2 sync + 1 output reg).
  - Mode switch edge to new pattern: 4 clk (adds RESTART).
- Reset mid-operation: immediate clear; no pending step survives.

Optional Feature:
- LED_SEQ_DEBOUNCE_EN defined: synced dsw2 is accepted into cfg only after it holds a constant value for 2^DB_W consecutive cycles. Any change restarts the count. dsw0/dsw1 masks are not debounced.
- Not defined: cfg = synced dsw2 directly; no debounce counter is instantiated.

Decomposition:
- Package led_seq_pkg holds:
  - mode enum (OFF, STATIC, CHASE, BOUNCE) and FSM state enum including RESTART;
  - NUM_LEDS=24;
  - cfg field bit positions for mode, brightness and speed.
- Sub-module led_seq_tick: prescaler plus step counter. Inputs clk, rst_n, clr, speed; output step.

Test Plan:
- Reset, DIV_W=4, dsw0=dsw1=FF, dsw2=0x0D (mode1, bright3) -> lb0=lb1=lb2=FF exactly 4 cycles after rst_n release; led[6:5]=1.
- dsw2=0x0E (CHASE, speed0, bright3) -> one lit bit advances every 16 cycles from lb0[0] through lb2[7]; after 24 steps back at lb0[0]; led[7] toggles each step.
- dsw2=0x0F (BOUNCE) -> pos sequence 0..23,22..0,1; led[4:0] matches pos every step.
- STATIC, bright=0 (dsw2=0x01), dsw0=0xA5 -> lb0 is 0xA5 for 64 of every 256 cycles and 0 otherwise; lb1 follows dsw1.
- CHASE at pos 10: switch to BOUNCE on the cycle of a step -> step dropped, 1 RESTART cycle, pos=0, next step after a full period.
- With LED_SEQ_DEBOUNCE_EN, DB_W=4: mode glitch shorter than 16 cycles -> no state change. Held mode -> change occurs 16 cycles after the sync delay.
